// File: rtl/pipe_div_unit.sv
// ============================================================================
// Module      : pipe_div_unit
// Description : Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the
//               EXE stage; r feeds HI, q feeds LO. Optional macro
//               DIV_EARLY_OUT_EN skips CALC when b=0 or |a|<|b|.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dq_q, dq_d;
   logic [WIDTH-1:0] babs_q, babs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] qo_q, qo_d;
   logic [WIDTH-1:0] ro_q, ro_d;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic             early;
   logic [WIDTH:0]   trial;
   logic             take;
   logic [WIDTH-1:0] diff;

   assign a_abs = (sign && a[WIDTH-1]) ? -a : a;
   assign b_abs = (sign && b[WIDTH-1]) ? -b : b;

`ifdef DIV_EARLY_OUT_EN
   assign early = (b == '0) || (a_abs < b_abs);
`else
   assign early = 1'b0;
`endif

   // Trial subtraction is one bit wider so divisors >= 2^(WIDTH-1) still work.
   assign trial = {rem_q, dq_q[WIDTH-1]};
   assign take  = trial[WIDTH] || (trial[WIDTH-1:0] >= babs_q);
   assign diff  = trial[WIDTH-1:0] - babs_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dq_d    = dq_q;
      babs_d  = babs_q;
      a_d     = a_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      qo_d    = qo_q;
      ro_d    = ro_q;
      case (state_q)
         S_CALC: begin
            rem_d = take ? diff : trial[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], take};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (dz_q) begin
               qo_d = '1;
               ro_d = a_q;
            end else begin
               qo_d = negq_q ? -dq_q : dq_q;
               ro_d = negr_q ? -rem_q : rem_q;
            end
            state_d = S_DONE;
         end
         default: begin
            // IDLE and DONE both accept a new request.
            if (start) begin
               negq_d = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
               negr_d = sign && a[WIDTH-1];
               dz_d   = (b == '0);
               a_d    = a;
               babs_d = b_abs;
               cnt_d  = '0;
               if (early) begin
                  rem_d   = a_abs;
                  dq_d    = '0;
                  state_d = S_FIX;
               end else begin
                  rem_d   = '0;
                  dq_d    = a_abs;
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         babs_q  <= '0;
         a_q     <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         qo_q    <= '0;
         ro_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dq_q    <= dq_d;
         babs_q  <= babs_d;
         a_q     <= a_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         qo_q    <= qo_d;
         ro_q    <= ro_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign q    = qo_q;
   assign r    = ro_q;

endmodule

`default_nettype wire
